// File: rtl/wb_regfile_pipe.sv
// ---------------------------------------------------------------------------
// wb_regfile_pipe
//
// Register file and write-back stage for the PIPE processor. The register
// array is held in flops. The W-stage instruction code selects which of the
// two write ports (E and M) may write. Two asynchronous read ports serve the
// decode stage. A non-AOK status sets a sticky halt. A saturating counter
// tracks retired instructions.
//
// Optional feature: define WB_BYPASS_EN so that the read ports forward the
// write data of the current W-stage instruction in the same cycle. When a
// read address matches both write ports, the M-port data is returned.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   W_stat       W-stage status (0 AOK, 1 HLT, 2 ADR, 3 INS)
//   W_icode      W-stage instruction code (0 halt .. 11 popq)
//   W_dstE       E-port destination register (RNONE = no write)
//   W_dstM       M-port destination register (RNONE = no write)
//   W_valE       E-port write data
//   W_valM       M-port write data
//   srcA, srcB   read port addresses
//   valA, valB   read port data (0 for RNONE or an unimplemented index)
//   halted       sticky halt flag, cleared only by rst
//   retired_cnt  saturating count of retired non-nop instructions
// ---------------------------------------------------------------------------
module wb_regfile_pipe #(
    parameter int                 DATA_W   = 64,
    parameter int                 ADDR_W   = 4,
    parameter int                 NREGS    = 15,
    parameter int                 RSP_IDX  = 4,
    parameter logic [DATA_W-1:0]  RSP_INIT = '0,
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        W_stat,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_dstE,
    input  logic [ADDR_W-1:0] W_dstM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [ADDR_W-1:0] RNONE    = '1;
    localparam logic [1:0]        STAT_AOK = 2'd0;

    // One bit per icode. The E port is used by rrmovq/cmovXX (2), irmovq (3),
    // OPq (6), call (8), ret (9), pushq (10) and popq (11).
    localparam logic [15:0] E_WRITERS = 16'h0F4C;
    // The M port is used by mrmovq (5) and popq (11).
    localparam logic [15:0] M_WRITERS = 16'h0820;
    // Retired instructions: every defined icode except nop (1).
    localparam logic [15:0] COUNTED   = 16'h0FFD;

    logic [DATA_W-1:0] regs [NREGS];

    logic commit;
    logic we_e;
    logic we_m;

    // True when the register index is implemented (not RNONE and below NREGS).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != RNONE) && (int'(a) < NREGS);
    endfunction

    assign commit = !rst && !halted && (W_stat == STAT_AOK);
    assign we_e   = commit && E_WRITERS[W_icode] && addr_ok(W_dstE);
    assign we_m   = commit && M_WRITERS[W_icode] && addr_ok(W_dstM);

    // NOTE: the array is built from flops, not a RAM macro, so every entry is
    // reset. A RAM-based version would have to clear its contents another way.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: sequential state uses non-blocking assignment, so all
                // flops update together and the order of reads is not a race.
                regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
            end
        end else begin
            if (we_e) begin
                regs[W_dstE] <= W_valE;
            end
            // Placed after the E write: if both ports target the same
            // register, the M data wins (popq %rsp keeps the popped value).
            if (we_m) begin
                regs[W_dstM] <= W_valM;
            end
        end
    end

    // The halt flag is sticky. Once it is set, commit stays low until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (!halted && (W_stat != STAT_AOK)) begin
            halted <= 1'b1;
        end
    end

    // Saturating retired-instruction counter. A halt bubble that arrives with
    // AOK status (icode 0) is counted; upstream bubbles are injected as nops.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (commit && COUNTED[W_icode] && (retired_cnt != '1)) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: each output is given a default first, so every path assigns
        // it and no latch is inferred.
        valA = '0;
        valB = '0;
        if (addr_ok(srcA)) begin
            valA = regs[srcA];
        end
        if (addr_ok(srcB)) begin
            valB = regs[srcB];
        end
`ifdef WB_BYPASS_EN
        // Forward the write of the current W-stage instruction. The M port is
        // checked first to match the write collision rule.
        if (we_m && (srcA == W_dstM)) begin
            valA = W_valM;
        end else if (we_e && (srcA == W_dstE)) begin
            valA = W_valE;
        end
        if (we_m && (srcB == W_dstM)) begin
            valB = W_valM;
        end else if (we_e && (srcB == W_dstE)) begin
            valB = W_valE;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile_pipe.sv
`timescale 1ns/1ps
module tb_wb_regfile_pipe;

    localparam int NR = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  W_stat;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA, valB, valA_s, valB_s;
    logic        halted, halted_s;
    logic [31:0] retired_cnt;
    logic [1:0]  retired_cnt_s;

    int errors = 0;
    int checks = 0;

    // Reference state: register contents, halt flag, and the two counters
    // (32-bit counter and 2-bit counter), each saturating at its own limit.
    logic [63:0]     m_regs [NR];
    logic            m_halted;
    longint unsigned m_cnt;
    int              m_cnt_s;

    always #50 clk = ~clk;

    wb_regfile_pipe #(.RSP_INIT(64'h100)) dut (
        .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .halted(halted), .retired_cnt(retired_cnt)
    );

    wb_regfile_pipe #(.RSP_INIT(64'h100), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .srcA(srcA), .srcB(srcB), .valA(valA_s), .valB(valB_s),
        .halted(halted_s), .retired_cnt(retired_cnt_s)
    );

    // Write-enable rules, taken directly from the instruction semantics.
    function automatic bit m_commit();
        return !rst && !m_halted && (W_stat == 2'd0);
    endfunction

    function automatic bit m_we_e();
        return m_commit() && (W_icode inside {4'd2, 4'd3, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11})
               && (int'(W_dstE) < NR);
    endfunction

    function automatic bit m_we_m();
        return m_commit() && (W_icode inside {4'd5, 4'd11}) && (int'(W_dstM) < NR);
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] a);
        logic [63:0] r;
        r = (int'(a) < NR) ? m_regs[a] : 64'd0;
`ifdef WB_BYPASS_EN
        if (m_we_m() && a == W_dstM)      r = W_valM;
        else if (m_we_e() && a == W_dstE) r = W_valE;
`endif
        return r;
    endfunction

    // Applies one rising edge to the reference state, using the inputs that
    // are present at that edge.
    function automatic void m_edge();
        bit e, m;
        e = m_we_e();
        m = m_we_m();
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = (i == 4) ? 64'h100 : 64'd0;
            m_halted = 1'b0;
            m_cnt    = 0;
            m_cnt_s  = 0;
        end else if (!m_halted) begin
            if (W_stat != 2'd0) begin
                m_halted = 1'b1;
            end else begin
                if (e) m_regs[W_dstE] = W_valE;
                if (m) m_regs[W_dstM] = W_valM;
                if (W_icode != 4'd1 && W_icode <= 4'd11) begin
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                    if (m_cnt_s < 3) m_cnt_s++;
                end
            end
        end
    endfunction

    task automatic drive(input logic r, input logic [1:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] ve, input logic [63:0] vm);
        rst = r; W_stat = st; W_icode = ic;
        W_dstE = de; W_dstM = dm; W_valE = ve; W_valM = vm;
    endtask

    // Inputs stay stable across the edge. The reference model follows the
    // edge, and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0);
    endtask

    task automatic test_reset();
        // A write presented together with rst must be discarded.
        drive(1'b1, 2'd0, 4'd3, 4'd2, 4'd4, 64'hBAD, 64'hBAD);
        tick();
        idle();
        for (int a = 0; a < 16; a++) begin
            srcA = 4'(a); srcB = 4'(15 - a); #1;
            checks++;
            if (valA !== m_read(srcA)) begin
                errors++; $display("FAIL reset_valA[%0d] got=%h exp=%h", a, valA, m_read(srcA));
            end
            checks++;
            if (valB !== m_read(srcB)) begin
                errors++; $display("FAIL reset_valB[%0d] got=%h exp=%h", 15 - a, valB, m_read(srcB));
            end
        end
        srcA = 4'd4; srcB = 4'd15; #1;
        checks++;
        if (valA !== 64'h100) begin errors++; $display("FAIL reset_rsp got=%h exp=100", valA); end
        checks++;
        if (valB !== 64'd0) begin errors++; $display("FAIL reset_rnone got=%h exp=0", valB); end
        checks++;
        if (halted !== 1'b0 || retired_cnt !== 32'd0 || retired_cnt_s !== 2'd0) begin
            errors++; $display("FAIL reset_status halted=%b cnt=%0d cnt_s=%0d exp 0/0/0",
                               halted, retired_cnt, retired_cnt_s);
        end
    endtask

    task automatic test_irmovq();
        drive(1'b0, 2'd0, 4'd3, 4'd2, 4'hF, 64'hDEADBEEF, 64'd0);
        srcA = 4'd2; #1;
`ifdef WB_BYPASS_EN
        checks++;
        if (valA !== 64'hDEADBEEF) begin
            errors++; $display("FAIL irmovq_bypass got=%h exp=deadbeef", valA);
        end
`else
        checks++;
        if (valA !== 64'd0) begin errors++; $display("FAIL irmovq_pre got=%h exp=0", valA); end
`endif
        tick();
        idle();
        srcA = 4'd2; #1;
        checks++;
        if (valA !== 64'hDEADBEEF) begin errors++; $display("FAIL irmovq got=%h exp=deadbeef", valA); end
        checks++;
        if (retired_cnt !== 32'd1) begin errors++; $display("FAIL irmovq_cnt got=%0d exp=1", retired_cnt); end
    endtask

    task automatic test_popq_rsp();
        drive(1'b0, 2'd0, 4'd11, 4'd4, 4'd4, 64'h108, 64'h55);
        tick();
        idle();
        srcA = 4'd4; #1;
        checks++;
        if (valA !== 64'h55) begin errors++; $display("FAIL popq_rsp got=%h exp=55", valA); end
        checks++;
        if (retired_cnt !== 32'd2) begin errors++; $display("FAIL popq_cnt got=%0d exp=2", retired_cnt); end
    endtask

    task automatic test_no_write();
        logic [31:0] base;
        logic [3:0]  icodes [4] = '{4'd4, 4'd7, 4'd1, 4'd2};
        logic [3:0]  dsts   [4] = '{4'd3, 4'd5, 4'd6, 4'hF};
        int          incs   [4] = '{1, 1, 0, 1};
        base = retired_cnt;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'd0, icodes[k], dsts[k], 4'd7, 64'hFACE_0000 + 64'(k), 64'hCAFE);
            tick();
            idle();
            base = base + 32'(incs[k]);
            checks++;
            if (retired_cnt !== base) begin
                errors++; $display("FAIL nowrite_cnt icode=%0d got=%0d exp=%0d", icodes[k], retired_cnt, base);
            end
            for (int a = 0; a < NR; a++) begin
                srcA = 4'(a); #1;
                checks++;
                if (valA !== m_read(srcA)) begin
                    errors++; $display("FAIL nowrite_reg icode=%0d r%0d got=%h exp=%h",
                                       icodes[k], a, valA, m_read(srcA));
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [63:0] r1;
        logic [31:0] cnt0;
        srcA = 4'd1; #1;
        r1 = m_read(4'd1);
        cnt0 = retired_cnt;
        drive(1'b0, 2'd2, 4'd6, 4'd1, 4'hF, 64'd7, 64'd0);
        tick();
        idle();
        srcA = 4'd1; #1;
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", halted); end
        checks++;
        if (valA !== r1) begin errors++; $display("FAIL halt_reg1 got=%h exp=%h", valA, r1); end
        checks++;
        if (retired_cnt !== cnt0) begin errors++; $display("FAIL halt_cnt got=%0d exp=%0d", retired_cnt, cnt0); end
        drive(1'b0, 2'd0, 4'd3, 4'd1, 4'hF, 64'h99, 64'd0);
        tick();
        idle();
        srcA = 4'd1; #1;
        checks++;
        if (valA !== r1 || retired_cnt !== cnt0 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_frozen reg1=%h cnt=%0d halted=%b exp %h/%0d/1",
                               valA, retired_cnt, halted, r1, cnt0);
        end
        drive(1'b1, 2'd0, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0);
        tick();
        idle();
        #1;
        checks++;
        if (halted !== 1'b0 || retired_cnt !== 32'd0) begin
            errors++; $display("FAIL halt_clear halted=%b cnt=%0d exp 0/0", halted, retired_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic r;
            logic [1:0] st;
            logic [3:0] de, dm;
            r  = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            st = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            de = 4'($urandom_range(0, 15));
            dm = ($urandom_range(0, 3) == 0) ? de : 4'($urandom_range(0, 15));
            drive(r, st, 4'($urandom_range(0, 15)), de, dm,
                  {$urandom, $urandom}, {$urandom, $urandom});
            srcA = ($urandom_range(0, 1) == 1) ? de : 4'($urandom_range(0, 15));
            srcB = ($urandom_range(0, 1) == 1) ? dm : 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (valA !== m_read(srcA) || valB !== m_read(srcB)) begin
                errors++; $display("FAIL rand_read n=%0d A[%0d]=%h exp %h B[%0d]=%h exp %h",
                                   n, srcA, valA, m_read(srcA), srcB, valB, m_read(srcB));
            end
            tick();
            checks++;
            if (halted !== m_halted || retired_cnt !== m_cnt[31:0] ||
                retired_cnt_s !== 2'(m_cnt_s) || halted_s !== m_halted) begin
                errors++; $display("FAIL rand_state n=%0d halted=%b/%b cnt=%0d/%0d cnt_s=%0d/%0d",
                                   n, halted, m_halted, retired_cnt, m_cnt[31:0], retired_cnt_s, m_cnt_s);
            end
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 2'd0, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 2'd0, 4'd6, 4'($urandom_range(0, 14)), 4'hF, {$urandom, $urandom}, 64'd0);
            tick();
            checks++;
            if (retired_cnt_s !== 2'((k < 3) ? k : 3)) begin
                errors++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, retired_cnt_s, (k < 3) ? k : 3);
            end
        end
        idle();
        #1;
        checks++;
        if (retired_cnt !== 32'd5) begin errors++; $display("FAIL sat_wide got=%0d exp=5", retired_cnt); end
    endtask

    initial begin
        m_halted = 1'b0; m_cnt = 0; m_cnt_s = 0;
        for (int i = 0; i < NR; i++) m_regs[i] = 64'd0;
        srcA = 4'd0; srcB = 4'd0;
        test_reset();
        test_irmovq();
        test_popq_rsp();
        test_no_write();
        test_halt();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
